router_output_arbiter: RTL

ROUTER_OUTPUT_ARBITER -- requirements
Module: router_output_arbiter

---
 rtl/noc.sv | 11 +
 rtl/router_output_arbiter.sv | 118 +++++++++++
 2 files changed

// File: rtl/noc.sv
// Shared network-on-chip constants: router port numbering.
package noc;

    localparam int kNumPorts  = 5;
    localparam int kNorthPort = 0;
    localparam int kSouthPort = 1;
    localparam int kWestPort  = 2;
    localparam int kEastPort  = 3;
    localparam int kLocalPort = 4;

endpackage

// File: rtl/router_output_arbiter.sv
// Wormhole output-port arbiter for a 5-port mesh router.
// Round-robin among inputs whose lookahead route selects this output, holds the
// output for the whole packet once a head flit wins, and gates every transfer on
// downstream credits. Grant is combinational from registered state.
module router_output_arbiter #(
    parameter int PortId  = noc::kLocalPort,
    parameter int Credits = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [4:0] request,
    input  logic [4:0] tail,
    input  logic       credit_in,
    output logic [4:0] grant,
    output logic       valid_out,
    output logic [3:0] credit_count,
    output logic       credit_error
);

    typedef enum logic {
        IDLE,
        LOCKED
    } state_t;

    // A flit never returns through the port it arrived on.
    localparam logic [4:0] kUturnMask = 5'(1 << PortId);
    localparam logic [3:0] kCredits   = 4'(Credits);

    state_t     state;
    logic [2:0] owner;
    logic [2:0] pointer;

    logic [4:0] masked;
    logic [2:0] winner;
    logic       found;
    logic [3:0] scan_sum;
    logic [2:0] scan_idx;
    logic [2:0] granted_idx;
    logic       granted_tail;
    logic [2:0] next_pointer;

    assign masked = request & ~kUturnMask;

    // Round-robin search: first masked requester at or after pointer, modulo 5.
    // NOTE: every variable gets a default before the loop so no latch is inferred.
    always_comb begin
        winner   = '0;
        found    = 1'b0;
        scan_sum = '0;
        scan_idx = '0;
        for (int k = 0; k < 5; k++) begin
            scan_sum = {1'b0, pointer} + 4'(k);
            scan_idx = (scan_sum >= 4'd5) ? 3'(scan_sum - 4'd5) : scan_sum[2:0];
            if (!found && masked[scan_idx]) begin
                found  = 1'b1;
                winner = scan_idx;
            end
        end
    end

    // Transfer grant: owner only while locked, round-robin winner while idle,
    // nothing during reset or without a downstream credit.
    always_comb begin
        grant = '0;
        if (rst && credit_count != 4'd0) begin
            if (state == LOCKED) begin
                if (masked[owner]) begin
                    grant[owner] = 1'b1;
                end
            end else if (found) begin
                grant[winner] = 1'b1;
            end
        end
    end

    assign valid_out    = |grant;
    assign granted_idx  = (state == LOCKED) ? owner : winner;
    assign granted_tail = tail[granted_idx];
    assign next_pointer = (granted_idx == 3'd4) ? 3'd0 : granted_idx + 3'd1;

    // Packet-lock FSM and round-robin pointer; pointer advances only past a tail.
    // NOTE: sequential state uses non-blocking assignments so all registers
    // update together from the values seen before the edge.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state   <= IDLE;
            owner   <= '0;
            pointer <= '0;
        end else if (valid_out) begin
            if (granted_tail) begin
                state   <= IDLE;
                pointer <= next_pointer;
            end else if (state == IDLE) begin
                state <= LOCKED;
                owner <= winner;
            end
        end
    end

    // Downstream credit counter with a sticky overflow flag.
    always_ff @(posedge clk) begin
        if (!rst) begin
            credit_count <= kCredits;
            credit_error <= 1'b0;
        end else begin
            if (credit_in && !valid_out) begin
                if (credit_count == kCredits) begin
                    credit_error <= 1'b1;
                end else begin
                    credit_count <= credit_count + 4'd1;
                end
            end else if (valid_out && !credit_in) begin
                credit_count <= credit_count - 4'd1;
            end
        end
    end

endmodule
